// File: rtl/mvm_driver.sv
// mvm_driver: buffers a k*k matrix and k-vector, replays them to a matrix-vector
// multiplier with load/start pulses, then collects k results. RD_LAT must be >= 1.
module mvm_driver #(
  parameter int k       = 4,
  parameter int b       = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [b-1:0]   in_data,
  output logic           in_ready,
  output logic           startMatrix,
  output logic           startVector,
  output logic           start,
  output logic [b-1:0]   mvm_data,
  input  logic           done,
  input  logic [2*b-1:0] mvm_result,
  output logic           out_valid,
  output logic [2*b-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           timeout_err
);

  localparam int unsigned NM = k * k;
  localparam int unsigned NW = k * k + k;
  localparam int unsigned CW = $clog2(NW);
  localparam int unsigned WW = $clog2(TIMEOUT + RD_LAT + k + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_M, SEND_V, START, WAIT_DONE, COLLECT
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [WW-1:0]  r_wd;
  logic           r_armed;
  logic [b-1:0]   r_buf [NW];
  logic           r_in_ready;
  logic           r_start_m;
  logic           r_start_v;
  logic           r_start;
  logic [b-1:0]   r_mvm_data;
  logic           r_out_valid;
  logic [2*b-1:0] r_out_data;
  logic           r_out_last;
  logic           r_busy;
  logic           r_timeout_err;

  logic           w_accept;
  logic           w_cnt_last;
  logic [CW-1:0]  w_cnt_next;
  logic [WW-1:0]  w_col;

  assign w_accept   = in_valid & r_in_ready;
  assign w_cnt_last = (r_cnt == CW'(NW - 1));
  assign w_cnt_next = w_cnt_last ? '0 : r_cnt + CW'(1);
  // In COLLECT the watchdog is reused as the cycle index after done (1-based).
  assign w_col      = r_wd + WW'(1);

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_cnt] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_wd          <= '0;
      r_armed       <= 1'b0;
      r_in_ready    <= 1'b0;
      r_start_m     <= 1'b0;
      r_start_v     <= 1'b0;
      r_start       <= 1'b0;
      r_mvm_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start_m   <= 1'b0;
      r_start_v   <= 1'b0;
      r_start     <= 1'b0;
      r_mvm_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state       <= LOAD;
            r_busy        <= 1'b1;
            r_cnt         <= w_cnt_next;
            r_timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_last) begin
              r_state    <= SEND_M;
              r_in_ready <= 1'b0;
              r_start_m  <= 1'b1;
            end
          end
        end
        SEND_M: begin
          if (r_cnt == CW'(NM)) begin
            r_state <= SEND_V;
            r_armed <= 1'b0;
          end else begin
            r_mvm_data <= r_buf[r_cnt];
            r_cnt      <= w_cnt_next;
          end
        end
        // r_armed marks that the idle gap and the start pulse are behind us;
        // the vector is finished once the counter has wrapped back to 0.
        SEND_V: begin
          if (!r_armed) begin
            r_start_v <= 1'b1;
            r_armed   <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state <= START;
            r_armed <= 1'b0;
          end else begin
            r_mvm_data <= r_buf[r_cnt];
            r_cnt      <= w_cnt_next;
          end
        end
        START: begin
          if (!r_armed) begin
            r_start <= 1'b1;
            r_armed <= 1'b1;
          end else begin
            r_state <= WAIT_DONE;
            r_armed <= 1'b0;
            r_wd    <= '0;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            r_state <= COLLECT;
            r_wd    <= '0;
          end else if (r_wd == WW'(TIMEOUT - 1)) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_timeout_err <= 1'b1;
            r_wd          <= '0;
          end else begin
            r_wd <= w_col;
          end
        end
        COLLECT: begin
          r_wd <= w_col;
          if ((w_col >= WW'(RD_LAT)) && (w_col < WW'(RD_LAT + k))) begin
            r_out_valid <= 1'b1;
            r_out_data  <= mvm_result;
            r_out_last  <= (w_col == WW'(RD_LAT + k - 1));
          end
          if (w_col == WW'(RD_LAT + k)) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_wd       <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign startMatrix = r_start_m;
  assign startVector = r_start_v;
  assign start       = r_start;
  assign mvm_data    = r_mvm_data;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mvm_driver.sv
// Self-checking bench for mvm_driver: timeline-based reference model compared every
// cycle, a multiplier stub answering done, and literal checks on result words.
module tb_mvm_driver;

  localparam int K       = 4;
  localparam int B       = 8;
  localparam int RW      = 2 * B;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 256;
  localparam int NM      = K * K;
  localparam int NW      = K * K + K;
  localparam int WST     = NM + K + 5;  // first wait cycle, counted from the startMatrix cycle
  localparam logic [RW-1:0] JUNK = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [B-1:0]  in_data;
  logic          in_ready;
  logic          startMatrix;
  logic          startVector;
  logic          start;
  logic [B-1:0]  mvm_data;
  logic          done;
  logic [RW-1:0] mvm_result;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          timeout_err;

  mvm_driver #(.k(K), .b(B), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .startMatrix(startMatrix), .startVector(startVector),
    .start(start), .mvm_data(mvm_data), .done(done), .mvm_result(mvm_result),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic          e_rdy = 1'b0, e_busy = 1'b0, e_terr = 1'b0;
  logic          e_sm = 1'b0, e_sv = 1'b0, e_st = 1'b0, e_ov = 1'b0, e_ol = 1'b0;
  logic [B-1:0]  e_md = '0;
  logic [RW-1:0] e_od = '0;
  int            m_acc = 0;
  int            m_s = -1;   // cycle index of a job in flight, 0 = startMatrix cycle
  int            m_j = -1;   // cycle index after the accepted done
  logic [B-1:0]  m_w [NW];
  logic [RW-1:0] m_y [K];
  longint        m_sum;

  always @(posedge clk) begin
    if (reset) begin
      e_rdy = 0; e_busy = 0; e_terr = 0; e_sm = 0; e_sv = 0; e_st = 0;
      e_md = '0; e_ov = 0; e_ol = 0; e_od = '0;
      m_acc = 0; m_s = -1; m_j = -1;
    end else begin
      e_sm = 0; e_sv = 0; e_st = 0; e_md = '0; e_ov = 0; e_ol = 0;
      if (m_j >= 0) begin
        if (m_j >= RD_LAT && m_j < RD_LAT + K) begin
          e_ov = 1; e_od = m_y[m_j - RD_LAT]; e_ol = (m_j == RD_LAT + K - 1);
        end
        if (m_j == RD_LAT + K) begin
          m_j = -1; e_busy = 0; e_rdy = 1;
        end else m_j++;
      end else if (m_s >= 0) begin
        if (m_s >= WST && done === 1'b1) begin
          m_s = -1; m_j = 1;
        end else if (m_s == WST + TIMEOUT - 1) begin
          m_s = -1; e_busy = 0; e_rdy = 1; e_terr = 1;
        end else begin
          m_s++;
          if (m_s >= 1 && m_s <= NM) e_md = m_w[m_s - 1];
          else if (m_s == NM + 2) e_sv = 1;
          else if (m_s >= NM + 3 && m_s <= NM + K + 2) e_md = m_w[m_s - 3];
          else if (m_s == NM + K + 4) e_st = 1;
        end
      end else begin
        if (in_valid === 1'b1 && e_rdy) begin
          m_w[m_acc] = in_data; e_busy = 1;
          if (m_acc == 0) e_terr = 0;
          m_acc++;
          if (m_acc == NW) begin
            m_acc = 0; m_s = 0; e_sm = 1; e_rdy = 0;
            for (int r = 0; r < K; r++) begin
              m_sum = 0;
              for (int c = 0; c < K; c++)
                m_sum += longint'($signed(m_w[r*K + c])) * longint'($signed(m_w[NM + c]));
              m_y[r] = RW'(m_sum);
            end
          end else e_rdy = 1;
        end else e_rdy = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("in_ready", in_ready, e_rdy);
    chk("busy", busy, e_busy);
    chk("timeout_err", timeout_err, e_terr);
    chk("startMatrix", startMatrix, e_sm);
    chk("startVector", startVector, e_sv);
    chk("start", start, e_st);
    chk("mvm_data", mvm_data, e_md);
    chk("out_valid", out_valid, e_ov);
    chk("out_last", out_last, e_ol);
    if (e_ov) chk("out_data", out_data, e_od);
  end

  // ---------------- stimulus and multiplier stub ----------------
  int            g_mat [NM];
  int            g_vec [K];
  logic [RW-1:0] got_q [$];
  int            last_idx;
  logic [RW-1:0] exp_r [K];

  function automatic logic [RW-1:0] stub_row(input int r);
    int s;
    s = 0;
    for (int c = 0; c < K; c++) s += g_mat[r*K + c] * g_vec[c];
    return RW'(s);
  endfunction

  task automatic load_job(input bit toggle, input int spur_at);
    int i, n;
    i = 0; n = 0;
    @(negedge clk);
    while (i < NW && n < 200) begin
      in_valid = toggle ? (n % 2 == 0) : 1'b1;
      in_data  = (i < NM) ? B'(g_mat[i]) : B'(g_vec[i - NM]);
      done     = (n == spur_at);
      if (in_valid && in_ready === 1'b1) i++;
      n++;
      @(negedge clk);
    end
    in_valid = 0; done = 0;
    chk("load_words", i, NW);
    chk("sm_after_last_word", startMatrix, 1'b1);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("start_seen", (n < 100), 1'b1);
  endtask

  task automatic run_compute(input int dly);
    got_q.delete(); last_idx = -1;
    wait_start();
    repeat (dly + 1) @(negedge clk);
    done = 1;
    @(negedge clk);
    done = 0;
    for (int j = 1; j <= RD_LAT + K + 2; j++) begin
      mvm_result = (j >= RD_LAT && j < RD_LAT + K) ? stub_row(j - RD_LAT) : JUNK;
      if (out_valid === 1'b1) begin
        got_q.push_back(out_data);
        if (out_last === 1'b1) last_idx = got_q.size() - 1;
      end
      @(negedge clk);
    end
    mvm_result = JUNK;
  endtask

  task automatic chk_results(input string tag);
    logic [RW-1:0] g;
    chk({tag, "_count"}, got_q.size(), K);
    for (int i = 0; i < K; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      chk({tag, "_word"}, g, exp_r[i]);
    end
    chk({tag, "_last_pos"}, last_idx, K - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    reset = 1; in_valid = 0; in_data = '0; done = 0; mvm_result = JUNK;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mvm_data", mvm_data, '0);
    chk("rst_out_data", out_data, '0);
    reset = 0;
    @(negedge clk);
    chk("rdy_after_release", in_ready, 1'b1);

    // all-ones matrix, vector 1..4, valid held
    g_mat = '{default: 1};
    g_vec = '{1, 2, 3, 4};
    load_job(1'b0, -1);
    run_compute(3);
    exp_r = '{16'd10, 16'd10, 16'd10, 16'd10};
    chk_results("ones");

    // toggling valid, mixed signs
    g_mat = '{1, 2, 3, 4, -1, 0, 1, 2, 5, 5, 5, 5, 0, 0, 0, -7};
    g_vec = '{2, -3, 1, 4};
    load_job(1'b1, -1);
    run_compute(0);
    exp_r = '{16'd15, 16'd7, 16'd20, 16'hFFE4};
    chk_results("toggle");

    // extremes: -65024 wraps to 16'h0200 in the 16-bit result word
    g_mat = '{default: -128};
    g_vec = '{default: 127};
    load_job(1'b0, -1);
    run_compute(7);
    exp_r = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    chk_results("extreme");

    // done never arrives
    g_mat = '{default: 1};
    g_vec = '{1, 2, 3, 4};
    load_job(1'b0, -1);
    wait_start();
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
    chk("timeout_cycles", cnt, 257);
    chk("timeout_err_set", timeout_err, 1'b1);
    chk("timeout_in_ready", in_ready, 1'b1);

    // new job clears the sticky flag; a done during load is ignored
    g_mat = '{3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
    g_vec = '{1, -2, 3, -4};
    load_job(1'b0, 5);
    chk("timeout_err_cleared", timeout_err, 1'b0);
    run_compute(2);
    exp_r = '{16'd3, 16'hFFFA, 16'd9, 16'hFFF4};
    chk_results("spurious");

    // reset in the middle of the matrix stream
    g_mat = '{default: 2};
    g_vec = '{1, 2, 3, 4};
    load_job(1'b0, -1);
    repeat (5) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("async_startMatrix", startMatrix, 1'b0);
    chk("async_mvm_data", mvm_data, '0);
    chk("async_busy", busy, 1'b0);
    chk("async_in_ready", in_ready, 1'b0);
    chk("async_out_data", out_data, '0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", busy, 1'b0);
    g_mat = '{default: 2};
    g_vec = '{1, 2, 3, 4};
    load_job(1'b0, -1);
    run_compute(1);
    exp_r = '{16'd20, 16'd20, 16'd20, 16'd20};
    chk_results("after_reset");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
